// File: rtl/lpm_mem_pkg.sv
// Shared definitions for the pipelined LPM memory latency model.
package lpm_mem_pkg;

    localparam int unsigned LPM_DATA_WIDTH = 704;
    localparam int unsigned LPM_TAG_WIDTH  = 8;
    localparam int unsigned MEMDELAY_RULE  = 0;

    typedef struct packed {
        logic                      valid;
        logic [31:0]               count;
        logic [LPM_TAG_WIDTH-1:0]  tag;
        logic [LPM_DATA_WIDTH-1:0] data;
    } lpm_entry_t;

endpackage

// File: rtl/lpm_mem_slot.sv
// One outstanding-request entry: load wins over clear, and a loaded entry skips
// that cycle's decrement.
module lpm_mem_slot
    import lpm_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LPM_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = LPM_TAG_WIDTH,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  clr_i,
    input  logic                  dec_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  rdy_o,
    output logic                  pend_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);

    logic                  valid_q, valid_d;
    logic [31:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    assign pend_o = valid_q && (count_q > 32'd1);
    assign rdy_o  = valid_q && (count_q == 32'd1);
    assign data_o = data_q;
    assign tag_o  = tag_q;

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (load_i) begin
            valid_d = 1'b1;
            count_d = 32'(LATENCY);
            data_d  = data_i;
            tag_d   = tag_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
            count_d = '0;
        end else if (dec_i && pend_o) begin
            count_d = count_q - 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            count_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: rtl/lpm_memory_pipe.sv
// In-order multi-outstanding memory latency model: ring buffer of countdown slots
// with guarded enqueue/dequeue and a scheduler-enabled decrement rule.
module lpm_memory_pipe
    import lpm_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LPM_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned TAG_WIDTH  = LPM_TAG_WIDTH
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         req__ENA,
    input  logic [DATA_WIDTH-1:0]        v,
    output logic                         req__RDY,
    input  logic                         resAccept__ENA,
    output logic                         resAccept__RDY,
    output logic [DATA_WIDTH-1:0]        resValue,
    output logic                         resValue__RDY,
    output logic [TAG_WIDTH-1:0]         resTag,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    input  logic [0:0]                   rule_enable,
    output logic [0:0]                   rule_ready
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OccW-1:0]      occ_q, occ_d;
    logic [TAG_WIDTH-1:0] next_tag_q, next_tag_d;

    logic [DEPTH-1:0]      slot_rdy, slot_pend, slot_load, slot_clr;
    logic [DATA_WIDTH-1:0] slot_data [DEPTH];
    logic [TAG_WIDTH-1:0]  slot_tag  [DEPTH];

    logic req_fire, acc_fire, mem_fire;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign req__RDY       = (occ_q < OccW'(DEPTH));
    assign resAccept__RDY = slot_rdy[rptr_q];
    assign resValue__RDY  = slot_rdy[rptr_q];
    assign resValue       = slot_data[rptr_q];
    assign resTag         = slot_tag[rptr_q];
    assign occupancy      = occ_q;

    always_comb begin
        rule_ready                = '0;
        rule_ready[MEMDELAY_RULE] = |slot_pend;
    end

    assign req_fire = req__ENA && req__RDY;
    assign acc_fire = resAccept__ENA && resAccept__RDY;
    assign mem_fire = rule_enable[MEMDELAY_RULE] && rule_ready[MEMDELAY_RULE];

    always_comb begin
        slot_load = '0;
        slot_clr  = '0;
        if (req_fire) slot_load[wptr_q] = 1'b1;
        if (acc_fire) slot_clr[rptr_q]  = 1'b1;
    end

    always_comb begin
        wptr_d     = req_fire ? ptr_inc(wptr_q) : wptr_q;
        rptr_d     = acc_fire ? ptr_inc(rptr_q) : rptr_q;
        next_tag_d = req_fire ? next_tag_q + TAG_WIDTH'(1) : next_tag_q;
        occ_d      = occ_q;
        case ({req_fire, acc_fire})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            next_tag_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            next_tag_q <= next_tag_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        lpm_mem_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .LATENCY    (LATENCY)
        ) u_slot (
            .clk_i  (CLK),
            .rst_i  (RST),
            .load_i (slot_load[i]),
            .clr_i  (slot_clr[i]),
            .dec_i  (mem_fire),
            .data_i (v),
            .tag_i  (next_tag_q),
            .rdy_o  (slot_rdy[i]),
            .pend_o (slot_pend[i]),
            .data_o (slot_data[i]),
            .tag_o  (slot_tag[i])
        );
    end

endmodule

// File: tb/tb_lpm_memory_pipe.sv
// Scoreboard bench for lpm_memory_pipe: directed sequences push expected responses,
// a negedge monitor pops and compares every accepted response.
module tb_lpm_memory_pipe;

    localparam int unsigned DW = 704;
    localparam int unsigned TW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req__ENA;
    logic [DW-1:0] v;
    logic          req__RDY;
    logic          resAccept__ENA;
    logic          resAccept__RDY;
    logic [DW-1:0] resValue;
    logic          resValue__RDY;
    logic [TW-1:0] resTag;
    logic [2:0]    occupancy;
    logic [0:0]    rule_enable;
    logic [0:0]    rule_ready;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    lpm_memory_pipe dut (
        .CLK            (CLK),
        .RST            (RST),
        .req__ENA       (req__ENA),
        .v              (v),
        .req__RDY       (req__RDY),
        .resAccept__ENA (resAccept__ENA),
        .resAccept__RDY (resAccept__RDY),
        .resValue       (resValue),
        .resValue__RDY  (resValue__RDY),
        .resTag         (resTag),
        .occupancy      (occupancy),
        .rule_enable    (rule_enable),
        .rule_ready     (rule_ready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a response fires at the next posedge when ENA and RDY are both high.
    always @(negedge CLK) begin
        if (!RST && resAccept__ENA && resAccept__RDY) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_response", 64'(resTag), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                n_pops++;
                check("resp_tag", 64'(resTag), 64'(e.tag));
                check("resp_valid", 64'(resValue__RDY), 64'd1);
                n_checks++;
                if (resValue !== e.data) begin
                    n_fail++;
                    $display("FAIL resp_data: got low %0h high %0h expected low %0h high %0h",
                             resValue[31:0], resValue[DW-1 -: 32], e.data[31:0],
                             e.data[DW-1 -: 32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [TW-1:0] t);
        exp_t e;
        e.data = d;
        e.tag  = t;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input bit expect_empty);
        if (expect_empty) check("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        RST            = 1'b1;
        req__ENA       = 1'b0;
        resAccept__ENA = 1'b0;
        rule_enable    = 1'b1;
        v              = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (occupancy != 3'd0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_in_budget", 64'(occupancy), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        int            issued;
        int            pops0;
        int            guard;

        // Reset state
        do_reset(1'b0);
        @(negedge CLK);
        check("rst_req_rdy", 64'(req__RDY), 64'd1);
        check("rst_acc_rdy", 64'(resAccept__RDY), 64'd0);
        check("rst_val_rdy", 64'(resValue__RDY), 64'd0);
        check("rst_value_zero", 64'(|resValue), 64'd0);
        check("rst_tag", 64'(resTag), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_rule_ready", 64'(rule_ready), 64'd0);
        tick();

        // Single request, latency 4
        req__ENA = 1'b1;
        v        = DW'(8'hA5);
        push(DW'(8'hA5), 8'd0);
        tick();
        req__ENA = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            check($sformatf("single_not_rdy_t%0d", i), 64'(resAccept__RDY), 64'd0);
            tick();
        end
        resAccept__ENA = 1'b1;
        @(negedge CLK);
        check("single_rdy_t4", 64'(resAccept__RDY), 64'd1);
        tick();
        resAccept__ENA = 1'b0;
        @(negedge CLK);
        check("single_occ_after", 64'(occupancy), 64'd0);
        tick();

        // Back-to-back four, accepted as they appear
        do_reset(1'b1);
        resAccept__ENA = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req__ENA = 1'b1;
            v        = DW'(i + 1);
            push(DW'(i + 1), TW'(i));
            @(negedge CLK);
            check("b2b_req_rdy", 64'(req__RDY), 64'd1);
            tick();
        end
        req__ENA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (i == 0) check("b2b_full_blocks", 64'(req__RDY), 64'd0);
            check($sformatf("b2b_rdy_t%0d", i + 4), 64'(resAccept__RDY), 64'd1);
            check($sformatf("b2b_tag_t%0d", i + 4), 64'(resTag), 64'(i));
            tick();
        end
        @(negedge CLK);
        check("b2b_occ_after", 64'(occupancy), 64'd0);
        tick();

        // Full with simultaneous req and accept: only the accept fires
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            req__ENA = 1'b1;
            v        = DW'(8'h10 + i);
            push(DW'(8'h10 + i), TW'(i));
            tick();
        end
        req__ENA       = 1'b1;
        v              = DW'(8'h55);
        resAccept__ENA = 1'b1;
        @(negedge CLK);
        check("full_occ4", 64'(occupancy), 64'd4);
        check("full_req_rdy", 64'(req__RDY), 64'd0);
        check("full_head_rdy", 64'(resAccept__RDY), 64'd1);
        tick();
        resAccept__ENA = 1'b0;
        push(DW'(8'h55), 8'd4);
        @(negedge CLK);
        check("full_occ3", 64'(occupancy), 64'd3);
        check("full_req_rdy_next", 64'(req__RDY), 64'd1);
        tick();
        req__ENA = 1'b0;
        @(negedge CLK);
        check("full_occ_refill", 64'(occupancy), 64'd4);
        tick();
        resAccept__ENA = 1'b1;
        wait_drain(40);
        resAccept__ENA = 1'b0;

        // Stall: three disabled cycles push readiness to t+7
        do_reset(1'b1);
        req__ENA = 1'b1;
        v        = DW'(8'h77);
        push(DW'(8'h77), 8'd0);
        tick();
        req__ENA    = 1'b0;
        rule_enable = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 4) rule_enable = 1'b1;
            @(negedge CLK);
            check($sformatf("stall_not_rdy_t%0d", i), 64'(resAccept__RDY), 64'd0);
            if (i <= 3) check($sformatf("stall_rule_ready_t%0d", i), 64'(rule_ready), 64'd1);
            tick();
        end
        resAccept__ENA = 1'b1;
        @(negedge CLK);
        check("stall_rdy_t7", 64'(resAccept__RDY), 64'd1);
        check("stall_rule_idle_t7", 64'(rule_ready), 64'd0);
        tick();
        resAccept__ENA = 1'b0;

        // Reset with three outstanding discards them and restarts tags
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            req__ENA = 1'b1;
            v        = DW'(8'hE0 + i);
            tick();
        end
        req__ENA = 1'b0;
        RST      = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_occ", 64'(occupancy), 64'd0);
        check("midrst_acc_rdy", 64'(resAccept__RDY), 64'd0);
        check("midrst_req_rdy", 64'(req__RDY), 64'd1);
        tick();
        req__ENA = 1'b1;
        v        = DW'(8'h99);
        push(DW'(8'h99), 8'd0);
        tick();
        req__ENA       = 1'b0;
        resAccept__ENA = 1'b1;
        wait_drain(20);
        resAccept__ENA = 1'b0;

        // 300 requests streamed, tags wrap at 256
        do_reset(1'b1);
        resAccept__ENA = 1'b1;
        pops0  = n_pops;
        issued = 0;
        guard  = 0;
        while (issued < 300 && guard < 3000) begin
            if (req__RDY) begin
                d           = '0;
                d[31:0]     = (issued * 32'h0101_0101) ^ 32'hDEAD_BEEF;
                d[DW-1 -: 32] = 32'(issued);
                req__ENA    = 1'b1;
                v           = d;
                push(d, TW'(issued));
                issued++;
            end else begin
                req__ENA = 1'b0;
            end
            tick();
            guard++;
        end
        req__ENA = 1'b0;
        check("stream_issued", 64'(issued), 64'd300);
        wait_drain(40);
        check("stream_pops", 64'(n_pops - pops0), 64'd300);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        resAccept__ENA = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
